uart_result_tx: RTL and testbench
=================================

Name: uart_result_tx

Overview:
- Packetising UART transmitter driving `uart_tx`. It is the outbound counterpart of the receive path that feeds `target_pos_out1`/`target_pos_out2`.
- Accepts one classification result per handshake: class id plus target X/Y position.
- Serialises a fixed 5-byte frame, 8N1, LSB first: header, class, X, Y, checksum.
- Typically fired once per frame, after the vsync-aligned inference result is ready.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division), clock cycles per bit. Must be >= 2.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pkt_valid  input  1  result fields valid.
- pkt_ready  output  1  block can accept a packet.
- class_id  input  8  class index.
- pos_x  input  8  target X position.
- pos_y  input  8  target Y position.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- pkt_done  output  1  one-cycle pulse when the last stop bit has completed.

Behaviour:
- Single clock domain; all state updates on rising `clk`. Reset is synchronous, active-high.
- Reset values: `uart_tx`=1, `pkt_ready`=1, `busy`=0, `pkt_done`=0. Baud counter, bit index and byte index = 0. FSM = IDLE.
- Handshake:
  - Accept on the cycle where `pkt_valid && pkt_ready`.
  - `class_id`, `pos_x`, `pos_y` are registered on that edge; inputs are don't-care afterwards.
  - `pkt_ready` = 1 only in IDLE. `pkt_valid` while busy is ignored; nothing is queued.
- Checksum: (HEADER + class_id + pos_x + pos_y) mod 256. Computed on the accepted values and registered at accept.
- Byte order: HEADER, class_id, pos_x, pos_y, checksum.
- FSM states IDLE, START, DATA, STOP:
  - IDLE -> START on accept. `busy`=1 and `uart_tx`=0 from the cycle after the accept edge.
  - START: hold 0 for CLKS_PER_BIT cycles, then -> DATA with bit index 0.
  - DATA: drive bit[idx] of the current byte for CLKS_PER_BIT cycles each, idx 0..7. After idx 7 -> STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. Then:
    - byte index < 4: increment byte index and -> START. No inter-byte idle gap.
    - byte index = 4: -> IDLE. `pkt_done`=1 for exactly that one transition cycle; `busy`=0 and `pkt_ready`=1 in the same cycle.
- Timing:
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Frame duration = 50*CLKS_PER_BIT cycles, from first start-bit cycle to the `pkt_done` cycle.
- `uart_tx` is a registered output; no combinational glitches.
- Back-to-back frames: a packet accepted in the `pkt_done` cycle starts its start bit on the next cycle. Minimum inter-frame gap is therefore 1 cycle of idle high.
- Reset mid-frame: on the next edge `uart_tx`=1, `busy`=0, `pkt_ready`=1, no `pkt_done`. The partial frame is abandoned and the latched fields are discarded.
- Counter widths: baud counter is sized to hold CLKS_PER_BIT-1; bit index 3 bits; byte index 3 bits. No wrap beyond the defined ranges.

Test Plan:
1. Basic frame. Parameters CLK_FREQ=1000, BAUD_RATE=100 (10 clk/bit). Send class 0x03, X 0x40, Y 0x7F.
   -> Sampling at bit centres decodes A5 03 40 7F 67. `pkt_done` asserts exactly 500 cycles after the first start-bit cycle.
2. Checksum wrap. Send class 0xFF, X 0xFF, Y 0xFF.
   -> Checksum byte = 0xA2 (0x3A2 mod 256). Each byte has start=0 and stop=1.
3. Valid while busy. Hold `pkt_valid` high with new fields throughout frame 1.
   -> Frame 1 bytes unchanged. `pkt_ready`=0 throughout. Frame 2 start bit begins the cycle after `pkt_done`, carrying the fields present on that accept cycle.
4. Reset mid-frame. Assert `reset` during byte 2, bit 4.
   -> Next cycle: `uart_tx`=1, `busy`=0, `pkt_ready`=1, no `pkt_done` pulse. A subsequent packet transmits a complete, correct frame.
5. Idle and reset state. Run 200 cycles with no `pkt_valid`.
   -> `uart_tx` stays 1, `busy`=0, `pkt_done` never pulses.
6. Bit timing. Use CLKS_PER_BIT=2 (minimum).
   -> Every line transition is spaced at a multiple of 2 cycles. Frame length = 100 cycles; decode is correct.

Source files
------------

// File: rtl/uart_result_tx.sv
// Packetising 8N1 UART transmitter: sends HEADER, class, X, Y and an additive
// checksum as one 5-byte frame per accepted result, LSB first.
module uart_result_tx #(
  parameter int         CLK_FREQ     = 100_000_000,
  parameter int         BAUD_RATE    = 115200,
  parameter int         CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  input  logic [7:0] class_id,
  input  logic [7:0] pos_x,
  input  logic [7:0] pos_y,
  output logic       uart_tx,
  output logic       busy,
  output logic       pkt_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [2:0]       byte_idx, byte_idx_nxt;
  logic             tx_nxt;
  logic             done_nxt;
  logic             accept;
  logic             bit_end;
  logic [2:0]       bit_idx_inc;
  logic [7:0]       cur_byte;

  logic [7:0]       class_p0, pos_x_p0, pos_y_p0, csum_p0;

  function automatic logic [7:0] checksum(input logic [7:0] c,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
    return HEADER + c + x + y;
  endfunction

  assign pkt_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = pkt_valid && pkt_ready;
  assign bit_end     = (baud_cnt == BAUD_LAST);
  assign bit_idx_inc = bit_idx + 3'd1;

  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = class_p0;
      3'd2:    cur_byte = pos_x_p0;
      3'd3:    cur_byte = pos_y_p0;
      default: cur_byte = csum_p0;
    endcase
  end

  // stage p0: result fields and checksum captured on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      class_p0 <= class_id;
      pos_x_p0 <= pos_x;
      pos_y_p0 <= pos_y;
      csum_p0  <= checksum(class_id, pos_x, pos_y);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      uart_tx  <= 1'b1;
      pkt_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      uart_tx  <= tx_nxt;
      pkt_done <= done_nxt;
    end
  end

  // next line level is computed one cycle ahead so uart_tx comes straight from a flop
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    tx_nxt       = uart_tx;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (accept) begin
          state_nxt    = START;
          tx_nxt       = 1'b0;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          byte_idx_nxt = '0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = DATA;
          tx_nxt       = cur_byte[0];
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx_inc;
            tx_nxt      = cur_byte[bit_idx_inc];
          end
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (byte_idx == 3'd4) begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            byte_idx_nxt = byte_idx + 3'd1;
            state_nxt    = START;
            tx_nxt       = 1'b0;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed scoreboard bench for uart_result_tx: a 10 clk/bit instance for
// framing, handshake and reset behaviour, and a 2 clk/bit instance for timing.
module tb_uart_result_tx;

  localparam int N1 = 10;
  localparam int N2 = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       v1, v2;
  logic [7:0] c1, x1, y1, c2, x2, y2;
  logic       r1, r2, tx1, tx2, b1, b2, d1, d2;

  int         n_asserts = 0;
  int         n_fail    = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_result_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .HEADER(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .pkt_valid(v1), .pkt_ready(r1),
    .class_id(c1), .pos_x(x1), .pos_y(y1),
    .uart_tx(tx1), .busy(b1), .pkt_done(d1)
  );

  uart_result_tx #(.CLK_FREQ(200), .BAUD_RATE(100), .HEADER(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .pkt_valid(v2), .pkt_ready(r2),
    .class_id(c2), .pos_x(x2), .pos_y(y2),
    .uart_tx(tx2), .busy(b2), .pkt_done(d2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] model_csum(input logic [7:0] c, input logic [7:0] x,
                                            input logic [7:0] y);
    return 8'hA5 + c + x + y;
  endfunction

  task automatic push_frame(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] ck);
    exp_q.push_back(8'hA5);
    exp_q.push_back(c);
    exp_q.push_back(x);
    exp_q.push_back(y);
    exp_q.push_back(ck);
  endtask

  task automatic send(input bit sel, input logic [7:0] c, input logic [7:0] x,
                      input logic [7:0] y);
    @(negedge clk);
    check("ready_before_accept", sel ? r2 : r1, 1);
    if (sel) begin v2 = 1'b1; c2 = c; x2 = x; y2 = y; end
    else     begin v1 = 1'b1; c1 = c; x1 = x; y1 = y; end
    @(posedge clk);
    #1;
    if (sel) begin v2 = 1'b0; c2 = 8'($urandom); x2 = 8'($urandom); y2 = 8'($urandom); end
    else     begin v1 = 1'b0; c1 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom); end
  endtask

  // Samples every cycle of the frame on the falling edge; bit value taken at the centre.
  task automatic decode(input bit sel, input int n, input int max_wait, input string tag);
    int         w = 0;
    logic       s, first;
    logic [9:0] slots;
    logic [7:0] expv;
    logic       stable, ctl_ok, no_done;
    do begin
      @(negedge clk);
      w++;
    end while ((sel ? tx2 : tx1) !== 1'b0 && w < max_wait);
    check({tag, " start_seen"}, sel ? tx2 : tx1, 0);
    if ((sel ? tx2 : tx1) !== 1'b0) return;
    ctl_ok  = 1'b1;
    no_done = 1'b1;
    for (int j = 0; j < 5; j++) begin
      stable = 1'b1;
      slots  = '0;
      first  = 1'b0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < n; c++) begin
          if (!(j == 0 && b == 0 && c == 0)) @(negedge clk);
          s = sel ? tx2 : tx1;
          if (c == 0) first = s;
          else if (s !== first) stable = 1'b0;
          if (c == n / 2) slots[b] = s;
          if ((sel ? b2 : b1) !== 1'b1 || (sel ? r2 : r1) !== 1'b0) ctl_ok = 1'b0;
          if ((sel ? d2 : d1) !== 1'b0) no_done = 1'b0;
        end
      end
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check($sformatf("%s byte%0d value", tag, j), slots[8:1], expv);
      check($sformatf("%s byte%0d start", tag, j), slots[0], 0);
      check($sformatf("%s byte%0d stop", tag, j), slots[9], 1);
      check($sformatf("%s byte%0d bit_stable", tag, j), stable, 1);
    end
    check({tag, " busy1_ready0_in_frame"}, ctl_ok, 1);
    check({tag, " no_early_done"}, no_done, 1);
    @(negedge clk);
    check({tag, " done_at_50_bits"}, sel ? d2 : d1, 1);
    check({tag, " busy_at_done"}, sel ? b2 : b1, 0);
    check({tag, " ready_at_done"}, sel ? r2 : r1, 1);
    check({tag, " tx_at_done"}, sel ? tx2 : tx1, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       idle_ok;
    logic [7:0] px;

    reset = 1'b1;
    v1 = 1'b0; c1 = '0; x1 = '0; y1 = '0;
    v2 = 1'b0; c2 = '0; x2 = '0; y2 = '0;
    repeat (3) @(negedge clk);
    check("reset tx", tx1, 1);
    check("reset ready", r1, 1);
    check("reset busy", b1, 0);
    check("reset done", d1, 0);
    check("reset tx2", tx2, 1);
    reset = 1'b0;

    // Idle with no pkt_valid
    idle_ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || b1 !== 1'b0 || d1 !== 1'b0 || r1 !== 1'b1) idle_ok = 1'b0;
    end
    check("idle 200 cycles", idle_ok, 1);

    // Basic frame
    push_frame(8'h03, 8'h40, 8'h7F, 8'h67);
    send(1'b0, 8'h03, 8'h40, 8'h7F);
    decode(1'b0, N1, 3, "basic");

    // Checksum wrap
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hA2);
    send(1'b0, 8'hFF, 8'hFF, 8'hFF);
    decode(1'b0, N1, 3, "wrap");

    // pkt_valid held through a frame with changing fields, back-to-back accept
    push_frame(8'h11, 8'h22, 8'h33, model_csum(8'h11, 8'h22, 8'h33));
    push_frame(8'h5A, 8'hC3, 8'h0F, model_csum(8'h5A, 8'hC3, 8'h0F));
    @(negedge clk);
    check("b2b ready_before_accept", r1, 1);
    v1 = 1'b1; c1 = 8'h11; x1 = 8'h22; y1 = 8'h33;
    @(posedge clk);
    #1;
    c1 = 8'h5A; x1 = 8'hC3; y1 = 8'h0F;
    decode(1'b0, N1, 3, "busy_valid f1");
    decode(1'b0, N1, 1, "busy_valid f2");
    v1 = 1'b0;

    // Reset during byte 2, data bit 4
    px = 8'h96;
    send(1'b0, 8'h24, px, 8'h3C);
    @(negedge clk);
    check("midreset start", tx1, 0);
    repeat (25 * N1 + N1 / 2) @(negedge clk);
    check("midreset byte2 bit4", tx1, px[4]);
    reset = 1'b1;
    @(negedge clk);
    check("midreset tx", tx1, 1);
    check("midreset busy", b1, 0);
    check("midreset ready", r1, 1);
    check("midreset done", d1, 0);
    reset = 1'b0;
    idle_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || b1 !== 1'b0 || d1 !== 1'b0) idle_ok = 1'b0;
    end
    check("after reset idle", idle_ok, 1);
    push_frame(8'h07, 8'h80, 8'h01, model_csum(8'h07, 8'h80, 8'h01));
    send(1'b0, 8'h07, 8'h80, 8'h01);
    decode(1'b0, N1, 3, "post_reset");

    // Minimum bit period
    push_frame(8'hC4, 8'h3B, 8'h99, model_csum(8'hC4, 8'h3B, 8'h99));
    send(1'b1, 8'hC4, 8'h3B, 8'h99);
    decode(1'b1, N2, 3, "cpb2");

    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
